// File: rtl/hexpad_pkg.sv
// Shared types, key map and vector helpers for the hex-pad RAM loader.
package hexpad_pkg;

    localparam int KEY_W = 16;

    typedef enum logic [1:0] {
        S_ADDR = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2,
        S_WR   = 2'd3
    } stage_t;

    // Indexed by key-vector bit number; bit15 is key 1, bit0 is key D.
    localparam logic [3:0] KEY_HEX [KEY_W] = '{
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic key_is_multi(input logic [KEY_W-1:0] v);
        return (v & (v - KEY_W'(1))) != '0;
    endfunction

    function automatic logic key_is_onehot(input logic [KEY_W-1:0] v);
        return (v != '0) && !key_is_multi(v);
    endfunction

endpackage

// File: rtl/hexpad_key_debounce.sv
// Debounces the scanned key vector and turns clean 0 -> single-key transitions
// into one-cycle key events with the decoded hex digit.
module hexpad_key_debounce
    import hexpad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] keys_in,
    output logic             key_strobe,
    output logic [3:0]       key_code,
    output logic             multi_key_err
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_W-1:0] keys_r;
    logic [KEY_W-1:0] cand;
    logic [KEY_W-1:0] stable;
    logic [KEY_W-1:0] stable_d;
    logic [CNT_W-1:0] cnt;
    logic             press;
    logic             multi;
    logic [3:0]       hex;

    // Candidate must survive DEBOUNCE_CYCLES unchanged; the counter then
    // parks at its maximum so stable keeps tracking the held vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keys_r <= '0;
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            keys_r <= keys_in;
            if (keys_r != cand) begin
                cand <= keys_r;
                cnt  <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= cand;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // A press needs the previous stable value to be empty, which also
    // enforces a release between presses.
    assign press = (stable_d == '0) && key_is_onehot(stable);
    assign multi = key_is_multi(stable);

    always_comb begin
        hex = 4'h0;
        for (int i = 0; i < KEY_W; i++) begin
            if (stable[i]) begin
                hex = KEY_HEX[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_d      <= '0;
            key_strobe    <= 1'b0;
            key_code      <= 4'h0;
            multi_key_err <= 1'b0;
        end else begin
            stable_d   <= stable;
            key_strobe <= press;
            if (press) begin
                key_code <= hex;
            end
            if (multi) begin
                multi_key_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hexpad_ram_loader.sv
// Hex-pad programming controller: address key, two data nibbles, then a RAM write.
// Build option HEXPAD_LOADER_AUTOINC_EN: after a write, continue at the next address.
module hexpad_ram_loader
    import hexpad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int ADDR_W          = 4,
    parameter int DATA_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [KEY_W-1:0]  keys_in,
    input  logic              prog_en,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ack,
    output logic              key_strobe,
    output logic [3:0]        key_code,
    output logic [1:0]        stage,
    output logic              multi_key_err
);

    // Write handshake: wr_req rises the cycle after the low nibble is taken and
    // holds with wr_addr/wr_data stable until a one-cycle wr_ack; wr_req falls
    // the cycle after that ack. Acks seen while no request is pending are dropped.

    stage_t            state;
    stage_t            state_nx;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic              take_key;
    logic              key_is_exit;

    hexpad_key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk           (clk),
        .reset         (reset),
        .keys_in       (keys_in),
        .key_strobe    (key_strobe),
        .key_code      (key_code),
        .multi_key_err (multi_key_err)
    );

    assign take_key = key_strobe && prog_en;

`ifdef HEXPAD_LOADER_AUTOINC_EN
    assign key_is_exit = (key_code == 4'hD);
`else
    assign key_is_exit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_ADDR;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_ADDR: begin
                if (take_key) begin
                    state_nx = S_HI;
                end
            end
            S_HI: begin
                if (!prog_en) begin
                    state_nx = S_ADDR;
                end else if (key_strobe) begin
                    state_nx = key_is_exit ? S_ADDR : S_LO;
                end
            end
            S_LO: begin
                if (!prog_en) begin
                    state_nx = S_ADDR;
                end else if (key_strobe) begin
                    state_nx = S_WR;
                end
            end
            S_WR: begin
                if (wr_ack) begin
`ifdef HEXPAD_LOADER_AUTOINC_EN
                    state_nx = prog_en ? S_HI : S_ADDR;
`else
                    state_nx = S_ADDR;
`endif
                end
            end
            default: state_nx = S_ADDR;
        endcase
    end

    // Address and data are only loaded on accepted keys, so they stay frozen
    // throughout S_WR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg <= '0;
            data_reg <= '0;
        end else begin
            if (state == S_ADDR && take_key) begin
                addr_reg <= ADDR_W'(key_code);
            end
            if (state == S_HI && take_key && !key_is_exit) begin
                data_reg[DATA_W-1 -: 4] <= key_code;
            end
            if (state == S_LO && take_key) begin
                data_reg[3:0] <= key_code;
            end
`ifdef HEXPAD_LOADER_AUTOINC_EN
            if (state == S_WR && wr_ack) begin
                addr_reg <= addr_reg + ADDR_W'(1);
            end
`endif
        end
    end

    always_comb begin
        wr_req  = (state == S_WR);
        wr_addr = addr_reg;
        wr_data = data_reg;
        stage   = state;
    end

endmodule

// File: tb/tb_hexpad_ram_loader.sv
// Directed bench for hexpad_ram_loader with a write scoreboard (DEBOUNCE_CYCLES=8).
module tb_hexpad_ram_loader;

    logic        clk;
    logic        reset;
    logic [15:0] keys_in;
    logic        prog_en;
    logic        wr_req;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        key_strobe;
    logic [3:0]  key_code;
    logic [1:0]  stage;
    logic        multi_key_err;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    logic [11:0] exp_q[$];

    hexpad_ram_loader #(
        .DEBOUNCE_CYCLES (8),
        .ADDR_W          (4),
        .DATA_W          (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .keys_in       (keys_in),
        .prog_en       (prog_en),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ack        (wr_ack),
        .key_strobe    (key_strobe),
        .key_code      (key_code),
        .stage         (stage),
        .multi_key_err (multi_key_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_strobe) strobe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one key and returns at the negedge where key_strobe is seen.
    task automatic press_key(input int idx, input logic [3:0] code);
        bit seen;
        seen = 1'b0;
        keys_in = 16'h1 << idx;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (key_strobe) begin
                seen = 1'b1;
                break;
            end
        end
        check("strobe_seen", 32'(seen), 1);
        check("key_code", 32'(key_code), 32'(code));
    endtask

    task automatic release_keys();
        keys_in = 16'h0;
        repeat (16) @(negedge clk);
    endtask

    task automatic tap(input int idx, input logic [3:0] code);
        press_key(idx, code);
        release_keys();
    endtask

    // Called at the strobe negedge of the final nibble.
    task automatic expect_write_start();
        logic [11:0] e;
        check("wr_req_at_strobe", 32'(wr_req), 0);
        @(negedge clk);
        check("wr_req_rise", 32'(wr_req), 1);
        check("stage_wr", 32'(stage), 3);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'(exp_q.size()), 1);
        end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(e[11:8]));
            check("wr_data", 32'(wr_data), 32'(e[7:0]));
        end
    endtask

    task automatic do_ack(input logic [1:0] exp_stage);
        repeat (4) @(negedge clk);
        check("wr_req_held", 32'(wr_req), 1);
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        check("wr_req_fall", 32'(wr_req), 0);
        check("stage_after_ack", 32'(stage), 32'(exp_stage));
    endtask

    initial begin
        int base;
        reset = 1'b1;
        keys_in = 16'h0;
        prog_en = 1'b0;
        wr_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_req", 32'(wr_req), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_strobe", 32'(key_strobe), 0);
        check("rst_code", 32'(key_code), 0);
        check("rst_stage", 32'(stage), 0);
        check("rst_err", 32'(multi_key_err), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Bouncing key never settles long enough; then a steady hold of key 1.
        base = strobe_cnt;
        for (int i = 0; i < 10; i++) begin
            keys_in = (i % 2 == 0) ? 16'h8000 : 16'h0000;
            repeat (3) @(negedge clk);
        end
        check("bounce_no_strobe", 32'(strobe_cnt - base), 0);
        keys_in = 16'h8000;
        repeat (20) @(negedge clk);
        check("hold_one_strobe", 32'(strobe_cnt - base), 1);
        check("hold_code", 32'(key_code), 32'h1);
        check("prog_off_stage", 32'(stage), 0);
        release_keys();

        // Two keys at once: no event, sticky error; a later clean press still works.
        base = strobe_cnt;
        keys_in = 16'h8800;
        repeat (30) @(negedge clk);
        check("multi_no_strobe", 32'(strobe_cnt - base), 0);
        check("multi_err_set", 32'(multi_key_err), 1);
        release_keys();
        tap(3, 4'h0);
        check("multi_err_sticky", 32'(multi_key_err), 1);
        check("multi_single_cnt", 32'(strobe_cnt - base), 1);

        // Ack with nothing pending is ignored.
        prog_en = 1'b1;
        @(negedge clk);
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_stage", 32'(stage), 0);
        check("stray_ack_req", 32'(wr_req), 0);

        // Full write: 5, A, 3.
        exp_q.push_back({4'h5, 8'hA3});
        tap(10, 4'h5);
        check("stage_hi", 32'(stage), 1);
        tap(12, 4'hA);
        check("stage_lo", 32'(stage), 2);
        press_key(13, 4'h3);
        expect_write_start();
        release_keys();
        do_ack(2'd0);

        // Partial entry abandoned by a one-cycle prog_en drop.
        tap(7, 4'h7);
        tap(4, 4'hC);
        check("abort_pre_stage", 32'(stage), 2);
        prog_en = 1'b0;
        @(negedge clk);
        prog_en = 1'b1;
        check("abort_stage", 32'(stage), 0);
        exp_q.push_back({4'h2, 8'h10});
        tap(14, 4'h2);
        tap(15, 4'h1);
        press_key(3, 4'h0);
        expect_write_start();
        release_keys();
        do_ack(2'd0);

        // prog_en drops mid-write; a key pressed during S_WR changes nothing.
        exp_q.push_back({4'h9, 8'hBE});
        tap(5, 4'h9);
        tap(8, 4'hB);
        press_key(1, 4'hE);
        expect_write_start();
        release_keys();
        prog_en = 1'b0;
        repeat (3) @(negedge clk);
        check("drop_req_held", 32'(wr_req), 1);
        prog_en = 1'b1;
        press_key(11, 4'h4);
        @(negedge clk);
        check("wr_key_stage", 32'(stage), 3);
        check("wr_key_addr", 32'(wr_addr), 32'h9);
        check("wr_key_data", 32'(wr_data), 32'hBE);
        release_keys();
        prog_en = 1'b0;
        do_ack(2'd0);
        prog_en = 1'b1;
        @(negedge clk);

`ifdef HEXPAD_LOADER_AUTOINC_EN
        exp_q.push_back({4'hF, 8'h11});
        tap(2, 4'hF);
        tap(15, 4'h1);
        press_key(15, 4'h1);
        expect_write_start();
        release_keys();
        do_ack(2'd1);
        exp_q.push_back({4'h0, 8'h22});
        tap(14, 4'h2);
        press_key(14, 4'h2);
        expect_write_start();
        release_keys();
        do_ack(2'd1);
        press_key(0, 4'hD);
        @(negedge clk);
        check("d_exit_stage", 32'(stage), 0);
        check("d_exit_req", 32'(wr_req), 0);
        release_keys();
`endif

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
